trn_tx_arb: RTL and testbench

// - Shares the PCIe endpoint TRN tx interface between NREQ TLP sources (rx ibuf2tlp, tx completion/read-request path, irq/stats writers).
// - Round-robin grant via the existing my_trn/drv_ep handshake; muxes the granted source's TRN tx onto the core.
// - Grants change only between TLPs, never mid-packet, and an unused grant is reclaimed after a timeout.

---
 rtl/trn_tx_arb_pkg.sv | 31 +++
 rtl/trn_tx_arb_if.sv | 37 +++
 rtl/trn_tx_arb_rr_pick.sv | 27 ++
 rtl/trn_tx_arb.sv | 131 +++++++++++++
 tb/tb_trn_tx_arb.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/trn_tx_arb_pkg.sv
// Shared types and constants for the TRN tx arbiter: FSM encoding, TRN beat payload and its idle value.
package trn_tx_arb_pkg;

    localparam int unsigned TD_W  = 64;
    localparam int unsigned REM_W = 8;

    localparam logic [REM_W-1:0] TREM_IDLE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_OWN
    } arb_state_e;

    typedef struct packed {
        logic [TD_W-1:0]  td;
        logic [REM_W-1:0] trem_n;
        logic             sof_n;
        logic             eof_n;
        logic             src_rdy_n;
    } trn_beat_t;

    localparam trn_beat_t TRN_IDLE = '{
        td:        '0,
        trem_n:    TREM_IDLE,
        sof_n:     1'b1,
        eof_n:     1'b1,
        src_rdy_n: 1'b1
    };

endpackage

// File: rtl/trn_tx_arb_if.sv
// TRN tx sharing bus: per-source request/drive handshake and TRN fields in, granted TRN stream out.
interface trn_tx_arb_if
    import trn_tx_arb_pkg::*;
#(
    parameter int unsigned NREQ = 3
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       drv_ep;
    logic [NREQ-1:0]       my_trn;
    logic [NREQ*TD_W-1:0]  src_td;
    logic [NREQ*REM_W-1:0] src_trem_n;
    logic [NREQ-1:0]       src_tsof_n;
    logic [NREQ-1:0]       src_teof_n;
    logic [NREQ-1:0]       src_tsrc_rdy_n;
    logic [TD_W-1:0]       trn_td;
    logic [REM_W-1:0]      trn_trem_n;
    logic                  trn_tsof_n;
    logic                  trn_teof_n;
    logic                  trn_tsrc_rdy_n;
    logic                  trn_tdst_rdy_n;
    logic                  in_pkt;

    // Arbiter side
    modport master (
        input  req, drv_ep, src_td, src_trem_n, src_tsof_n, src_teof_n, src_tsrc_rdy_n,
               trn_tdst_rdy_n,
        output my_trn, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, in_pkt
    );

    // Sources and core side
    modport slave (
        output req, drv_ep, src_td, src_trem_n, src_tsof_n, src_teof_n, src_tsrc_rdy_n,
               trn_tdst_rdy_n,
        input  my_trn, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, in_pkt
    );

endinterface

// File: rtl/trn_tx_arb_rr_pick.sv
// Round-robin priority encoder: first asserted request at or after ptr, wrapping mod NREQ.
module trn_tx_arb_rr_pick #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned SEL_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] sel_c,
    output logic             valid_c
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        sel_c   = '0;
        valid_c = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = SEL_W'((32'(ptr) + i) % NREQ);
            if (!valid_c && req[idx]) begin
                sel_c   = idx;
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trn_tx_arb.sv
// Round-robin owner of the endpoint TRN tx interface: grants one source at a time,
// switches only between TLPs, reclaims unused grants after a timeout, muxes the owner onto the core.
module trn_tx_arb
    import trn_tx_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned TMO_W = 4
) (
    input logic          clk,
    input logic          rst,
    trn_tx_arb_if.master bus
);

    localparam int unsigned      SEL_W   = $clog2(NREQ);
    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    arb_state_e       state, state_n;
    logic [SEL_W-1:0] sel, sel_n;
    logic [SEL_W-1:0] ptr, ptr_n;
    logic [TMO_W-1:0] tmo, tmo_n;
    logic [NREQ-1:0]  my_trn, my_trn_n;
    logic             in_pkt, in_pkt_n;
    logic             rel_c;
    logic [SEL_W-1:0] pick_sel_c;
    logic             pick_valid_c;
    trn_beat_t        beat_c;
    logic             beat_acc_c;

    trn_tx_arb_rr_pick #(
        .NREQ  (NREQ),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .sel_c   (pick_sel_c),
        .valid_c (pick_valid_c)
    );

    // Granted source straight onto the core; idle values whenever nobody holds the grant
    always_comb begin
        beat_c = TRN_IDLE;
        if (|my_trn) begin
            beat_c.td        = bus.src_td[TD_W*sel +: TD_W];
            beat_c.trem_n    = bus.src_trem_n[REM_W*sel +: REM_W];
            beat_c.sof_n     = bus.src_tsof_n[sel];
            beat_c.eof_n     = bus.src_teof_n[sel];
            beat_c.src_rdy_n = bus.src_tsrc_rdy_n[sel];
        end
    end

    assign beat_acc_c = !beat_c.src_rdy_n && !bus.trn_tdst_rdy_n;

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        ptr_n    = ptr;
        tmo_n    = tmo;
        my_trn_n = my_trn;
        in_pkt_n = in_pkt;
        rel_c    = 1'b0;

        // EOF wins so a single-beat TLP never opens a packet
        if (beat_acc_c && !beat_c.eof_n) begin
            in_pkt_n = 1'b0;
        end else if (beat_acc_c && !beat_c.sof_n) begin
            in_pkt_n = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (pick_valid_c) begin
                    sel_n    = pick_sel_c;
                    my_trn_n = NREQ'(1'b1) << pick_sel_c;
                    tmo_n    = '0;
                    state_n  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (bus.drv_ep[sel]) begin
                    tmo_n   = '0;
                    state_n = ST_OWN;
                end else if (!bus.req[sel] || (tmo + 1'b1) == TMO_MAX) begin
                    rel_c = 1'b1;
                end else begin
                    tmo_n = tmo + 1'b1;
                end
            end
            ST_OWN: begin
                // A source dropping drv_ep mid-TLP keeps the grant until its EOF is accepted
                if (!bus.drv_ep[sel] && !in_pkt_n) begin
                    rel_c = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (rel_c) begin
            my_trn_n = '0;
            ptr_n    = (sel == SEL_W'(NREQ - 1)) ? '0 : sel + 1'b1;
            tmo_n    = '0;
            state_n  = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            sel    <= '0;
            ptr    <= '0;
            tmo    <= '0;
            my_trn <= '0;
            in_pkt <= 1'b0;
        end else begin
            state  <= state_n;
            sel    <= sel_n;
            ptr    <= ptr_n;
            tmo    <= tmo_n;
            my_trn <= my_trn_n;
            in_pkt <= in_pkt_n;
        end
    end

    assign bus.my_trn         = my_trn;
    assign bus.in_pkt         = in_pkt;
    assign bus.trn_td         = beat_c.td;
    assign bus.trn_trem_n     = beat_c.trem_n;
    assign bus.trn_tsof_n     = beat_c.sof_n;
    assign bus.trn_teof_n     = beat_c.eof_n;
    assign bus.trn_tsrc_rdy_n = beat_c.src_rdy_n;

endmodule

// File: tb/tb_trn_tx_arb.sv
// Directed bench for trn_tx_arb: grant latency, rotation, timeout, late EOF, isolation and async reset.
module tb_trn_tx_arb;
    import trn_tx_arb_pkg::*;

    localparam int unsigned NREQ  = 3;
    localparam int unsigned TMO_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cnt;
    logic [63:0] seen[$];
    logic [63:0] expq[$];

    trn_tx_arb_if #(.NREQ(NREQ)) bus ();

    trn_tx_arb #(
        .NREQ  (NREQ),
        .TMO_W (TMO_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Record every beat the core accepts
    always @(negedge clk)
        if (!rst && !bus.trn_tsrc_rdy_n && !bus.trn_tdst_rdy_n)
            seen.push_back(bus.trn_td);

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_src(input int s);
        bus.src_td[64*s +: 64]   = 64'h0;
        bus.src_trem_n[8*s +: 8] = 8'hFF;
        bus.src_tsof_n[s]        = 1'b1;
        bus.src_teof_n[s]        = 1'b1;
        bus.src_tsrc_rdy_n[s]    = 1'b1;
    endtask

    task automatic set_beat(input int s, input logic [63:0] d, input bit sof, input bit eof);
        bus.src_td[64*s +: 64]   = d;
        bus.src_trem_n[8*s +: 8] = 8'h00;
        bus.src_tsof_n[s]        = !sof;
        bus.src_teof_n[s]        = !eof;
        bus.src_tsrc_rdy_n[s]    = 1'b0;
    endtask

    task automatic chk_idle_out(input string tag);
        chk({tag, "_my_trn"}, 64'(bus.my_trn), 64'd0);
        chk({tag, "_in_pkt"}, 64'(bus.in_pkt), 64'd0);
        chk({tag, "_td"}, bus.trn_td, 64'd0);
        chk({tag, "_trem"}, 64'(bus.trn_trem_n), 64'hFF);
        chk({tag, "_sof"}, 64'(bus.trn_tsof_n), 64'd1);
        chk({tag, "_eof"}, 64'(bus.trn_teof_n), 64'd1);
        chk({tag, "_rdy"}, 64'(bus.trn_tsrc_rdy_n), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req            = '0;
        bus.drv_ep         = '0;
        bus.trn_tdst_rdy_n = 1'b0;
        for (int s = 0; s < int'(NREQ); s++) idle_src(s);
        #1;
        chk_idle_out("rst");
        tick();
        tick();
        rst = 1'b0;
        seen.delete();
    endtask

    // Drive an nb-beat TLP from source s, one beat per cycle, checking the core side each beat
    task automatic send_tlp(input int s, input int nb, input logic [63:0] base, input string tag);
        for (int b = 0; b < nb; b++) begin
            set_beat(s, base + 64'(b), b == 0, b == nb - 1);
            #1;
            chk({tag, "_td"}, bus.trn_td, base + 64'(b));
            chk({tag, "_rdy"}, 64'(bus.trn_tsrc_rdy_n), 64'd0);
            chk({tag, "_in_pkt"}, 64'(bus.in_pkt), 64'(b != 0));
            tick();
        end
        idle_src(s);
    endtask

    task automatic chk_beats(input string tag, input logic [63:0] exp[$]);
        chk({tag, "_nbeats"}, 64'(seen.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < seen.size(); i++)
            chk({tag, "_beat"}, seen[i], exp[i]);
    endtask

    initial begin
        // Single requester, 3-beat TLP
        do_reset();
        bus.req = 3'b001;
        #1;
        chk("t1_pre", 64'(bus.my_trn), 64'd0);
        tick();
        chk("t1_grant", 64'(bus.my_trn), 64'b001);
        tick();
        bus.drv_ep[0] = 1'b1;
        send_tlp(0, 3, 64'h1000, "t1");
        chk("t1_in_pkt_end", 64'(bus.in_pkt), 64'd0);
        chk("t1_hold", 64'(bus.my_trn), 64'b001);
        bus.drv_ep[0] = 1'b0;
        bus.req       = '0;
        tick();
        chk("t1_release", 64'(bus.my_trn), 64'd0);
        expq = '{64'h1000, 64'h1001, 64'h1002};
        chk_beats("t1", expq);

        // All three requesting: rotation 0,1,2,0 with one idle cycle between owners
        do_reset();
        bus.req = 3'b111;
        tick();
        expq.delete();
        for (int k = 0; k < 4; k++) begin
            int s;
            s = k % 3;
            chk("t2_grant", 64'(bus.my_trn), 64'd1 << s);
            bus.drv_ep[s] = 1'b1;
            send_tlp(s, 2, 64'h2000 + 64'(16 * k), "t2");
            expq.push_back(64'h2000 + 64'(16 * k));
            expq.push_back(64'h2001 + 64'(16 * k));
            bus.drv_ep[s] = 1'b0;
            if (k == 3) bus.req = '0;
            tick();
            chk("t2_gap", 64'(bus.my_trn), 64'd0);
            tick();
        end
        chk("t2_after", 64'(bus.my_trn), 64'd0);
        chk_beats("t2", expq);

        // Unused grant reclaimed after 15 cycles; pointer moves on to source 2
        do_reset();
        bus.req = 3'b010;
        tick();
        cnt = 0;
        for (int i = 0; i < 40 && bus.my_trn == 3'b010; i++) begin
            cnt++;
            if (i == 5) bus.req[2] = 1'b1;
            tick();
        end
        chk("t3_grant_cycles", 64'(cnt), 64'd15);
        chk("t3_gap", 64'(bus.my_trn), 64'd0);
        tick();
        chk("t3_next", 64'(bus.my_trn), 64'b100);
        bus.req = '0;
        tick();
        tick();
        chk("t3_drop", 64'(bus.my_trn), 64'd0);

        // Source 2 drops drv_ep mid-TLP while the core stalls the EOF for 4 cycles
        do_reset();
        bus.req = 3'b100;
        tick();
        chk("t4_grant", 64'(bus.my_trn), 64'b100);
        bus.drv_ep[2] = 1'b1;
        set_beat(2, 64'h4000, 1'b1, 1'b0);
        tick();
        set_beat(2, 64'h4001, 1'b0, 1'b0);
        tick();
        bus.drv_ep[2]      = 1'b0;
        bus.req            = '0;
        bus.trn_tdst_rdy_n = 1'b1;
        set_beat(2, 64'h4002, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_hold", 64'(bus.my_trn), 64'b100);
            chk("t4_in_pkt", 64'(bus.in_pkt), 64'd1);
            tick();
        end
        bus.trn_tdst_rdy_n = 1'b0;
        #1;
        chk("t4_eof_cycle", 64'(bus.my_trn), 64'b100);
        tick();
        idle_src(2);
        chk("t4_release", 64'(bus.my_trn), 64'd0);
        chk("t4_in_pkt_end", 64'(bus.in_pkt), 64'd0);
        expq = '{64'h4000, 64'h4001, 64'h4002};
        chk_beats("t4", expq);

        // Non-granted source 1 drives 64'hDEAD beats while source 0 owns
        do_reset();
        set_beat(1, 64'hDEAD, 1'b1, 1'b1);
        #1;
        chk("t5_idle_rdy", 64'(bus.trn_tsrc_rdy_n), 64'd1);
        chk("t5_idle_td", bus.trn_td, 64'd0);
        bus.req = 3'b001;
        tick();
        chk("t5_grant", 64'(bus.my_trn), 64'b001);
        chk("t5_grant_rdy", 64'(bus.trn_tsrc_rdy_n), 64'd1);
        bus.drv_ep[0] = 1'b1;
        send_tlp(0, 3, 64'h5000, "t5");
        bus.drv_ep[0] = 1'b0;
        bus.req       = '0;
        tick();
        chk("t5_release", 64'(bus.my_trn), 64'd0);
        expq = '{64'h5000, 64'h5001, 64'h5002};
        chk_beats("t5", expq);

        // Async reset during beat 2 of a 4-beat TLP from source 1 (pointer currently 1)
        idle_src(1);
        seen.delete();
        bus.req = 3'b010;
        tick();
        chk("t6_grant", 64'(bus.my_trn), 64'b010);
        bus.drv_ep[1] = 1'b1;
        set_beat(1, 64'h6000, 1'b1, 1'b0);
        tick();
        set_beat(1, 64'h6001, 1'b0, 1'b0);
        tick();
        set_beat(1, 64'h6002, 1'b0, 1'b0);
        #1;
        chk("t6_beat2_td", bus.trn_td, 64'h6002);
        rst = 1'b1;
        #1;
        chk_idle_out("t6_rst");
        expq = '{64'h6000, 64'h6001};
        chk_beats("t6", expq);
        tick();
        idle_src(1);
        bus.drv_ep = '0;
        bus.req    = 3'b011;
        rst        = 1'b0;
        tick();
        chk("t6_post_grant", 64'(bus.my_trn), 64'b001);
        bus.req = '0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
